// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the CS delay-line length controller.
//   LEN_W_DEF     : default width of the delay length and related values
//   apply_state_e : states of the length-apply FSM
package delay_ctrl_pkg;

    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_QUIET = 2'd1,
        APPLY      = 2'd2
    } apply_state_e;

endpackage

// File: rtl/delay_len_ctrl_btn_debounce.sv
// Push-button debouncer: 2-FF synchroniser, free-running sample divider and
// an N-deep sample history. The stable level only changes when the whole
// history agrees.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_btn_raw     : raw asynchronous button input
//   o_sample_en   : one-clk tick, once every DIV clocks
//   o_btn_stable  : debounced button level
module btn_debounce
    import delay_ctrl_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int N   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_sample_en,
    output logic o_btn_stable
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [N-1:0]     r_hist;
    logic             r_stable;
    logic             w_tick;

    assign w_tick       = (r_div == DIV_W'(DIV - 1));
    assign o_sample_en  = w_tick;
    assign o_btn_stable = r_stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_div    <= '0;
            r_hist   <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick)
                r_hist <= {r_hist[N-2:0], r_sync2};
            // Mixed history keeps the previous level (hysteresis).
            if (&r_hist)
                r_stable <= 1'b1;
            else if (~|r_hist)
                r_stable <= 1'b0;
        end
    end

endmodule

// File: rtl/delay_len_ctrl.sv
// Delay-length controller for the variable CS delay line. Owns the applied
// length o_len. A short button press steps the target (wrapping at
// i_len_max), a long press zeroes it, and the host can load a value.
// The target is only copied to o_len after cs has been low for IDLE_CYC
// consecutive clocks, so the tap select never moves mid-frame.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_btn_raw     : raw push-button
//   i_cs          : chip select seen by the delay line
//   i_len_max     : wrap point of the target (range 0..i_len_max)
//   i_ext_load    : host load strobe, i_ext_len : host value
//   o_ext_ack     : pulse the clock after a host load
//   o_len         : applied delay length
//   o_len_upd     : pulse in the first cycle o_len shows a new value
//   o_pending     : target differs from o_len, waiting for a quiet bus
//   o_sample_en   : debounce sample tick, o_btn_stable : debounced level
module delay_len_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int DIV      = 50000,
    parameter int N        = 8,
    parameter int LONG     = 64,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int IDLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_btn_raw,
    input  logic             i_cs,
    input  logic [LEN_W-1:0] i_len_max,
    input  logic             i_ext_load,
    input  logic [LEN_W-1:0] i_ext_len,
    output logic             o_ext_ack,
    output logic [LEN_W-1:0] o_len,
    output logic             o_len_upd,
    output logic             o_pending,
    output logic             o_sample_en,
    output logic             o_btn_stable
);

    localparam int HOLD_W = $clog2(LONG + 1);
    localparam int QW     = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

    function automatic logic [LEN_W-1:0] f_min(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Wrap is explicit against the max, never by counter overflow.
    function automatic logic [LEN_W-1:0] f_wrap_inc(input logic [LEN_W-1:0] t,
                                                    input logic [LEN_W-1:0] m);
        return (t >= m) ? '0 : t + LEN_W'(1);
    endfunction

    logic              w_sample_en;
    logic              w_btn_stable;
    logic              r_stable_d;
    logic [HOLD_W-1:0] r_hold;
    logic              w_rise;
    logic              w_fall;
    logic              w_long_evt;
    logic              w_short_evt;
    logic [LEN_W-1:0]  r_target;
    logic [LEN_W-1:0]  r_len;
    logic              r_len_upd;
    logic              r_ext_ack;
    logic [QW-1:0]     r_quiet;
    apply_state_e      r_state;
    apply_state_e      w_state_nxt;
    logic              w_apply;

    btn_debounce #(
        .DIV (DIV),
        .N   (N)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .i_btn_raw    (i_btn_raw),
        .o_sample_en  (w_sample_en),
        .o_btn_stable (w_btn_stable)
    );

    assign o_sample_en  = w_sample_en;
    assign o_btn_stable = w_btn_stable;
    assign o_len        = r_len;
    assign o_len_upd    = r_len_upd;
    assign o_ext_ack    = r_ext_ack;

    // Button events. Hold saturates at LONG, so the long event fires once per
    // press and the release that follows is not a short press.
    assign w_rise      = w_btn_stable & ~r_stable_d;
    assign w_fall      = ~w_btn_stable & r_stable_d;
    assign w_long_evt  = w_sample_en & w_btn_stable & ~w_rise &
                         (r_hold == HOLD_W'(LONG - 1));
    assign w_short_evt = w_fall & (r_hold < HOLD_W'(LONG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_stable_d <= w_btn_stable;
            if (w_rise)
                r_hold <= '0;
            else if (w_sample_en && w_btn_stable && (r_hold != HOLD_W'(LONG)))
                r_hold <= r_hold + HOLD_W'(1);
        end
    end

    // Target register: a host load overrides a same-cycle button event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target  <= '0;
            r_ext_ack <= 1'b0;
        end else begin
            r_ext_ack <= i_ext_load;
            if (i_ext_load)
                r_target <= f_min(i_ext_len, i_len_max);
            else if (w_long_evt)
                r_target <= '0;
            else if (w_short_evt)
                r_target <= f_wrap_inc(r_target, i_len_max);
        end
    end

    // Apply FSM: state register and quiet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_quiet <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counting restarts on entry to WAIT_QUIET and on any cs high.
            if (r_state != WAIT_QUIET || i_cs)
                r_quiet <= '0;
            else
                r_quiet <= r_quiet + QW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (r_target != r_len) w_state_nxt = WAIT_QUIET;
            WAIT_QUIET: if (!i_cs && (r_quiet == QW'(IDLE_CYC - 1))) w_state_nxt = APPLY;
            APPLY:      w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_apply   = (r_state == APPLY);
        o_pending = (r_state != IDLE);
    end

    // The update pulse is registered with len so both appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= '0;
            r_len_upd <= 1'b0;
        end else begin
            r_len_upd <= w_apply && (r_target != r_len);
            if (w_apply)
                r_len <= r_target;
        end
    end

endmodule

// File: tb/tb_delay_len_ctrl.sv
module tb_delay_len_ctrl;

    localparam int DIV      = 16;
    localparam int N        = 3;
    localparam int LONG     = 8;
    localparam int LEN_W    = 4;
    localparam int IDLE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn = 1'b0;
    logic             cs = 1'b0;
    logic [LEN_W-1:0] len_max = 4'd15;
    logic             ext_load = 1'b0;
    logic [LEN_W-1:0] ext_len = '0;
    logic             o_ext_ack;
    logic [LEN_W-1:0] o_len;
    logic             o_len_upd;
    logic             o_pending;
    logic             o_sample_en;
    logic             o_btn_stable;

    int checks = 0;
    int errors = 0;

    logic [LEN_W-1:0] exp_len_q[$];
    bit               exp_ack_q[$];
    logic [LEN_W-1:0] mon_e;

    delay_len_ctrl #(
        .DIV(DIV), .N(N), .LONG(LONG), .LEN_W(LEN_W), .IDLE_CYC(IDLE_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_raw    (btn),
        .i_cs         (cs),
        .i_len_max    (len_max),
        .i_ext_load   (ext_load),
        .i_ext_len    (ext_len),
        .o_ext_ack    (o_ext_ack),
        .o_len        (o_len),
        .o_len_upd    (o_len_upd),
        .o_pending    (o_pending),
        .o_sample_en  (o_sample_en),
        .o_btn_stable (o_btn_stable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every len_upd / ext_ack pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_len_upd === 1'b1) begin
                if (exp_len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_len_upd: got len %0d expected no update", o_len);
                end else begin
                    mon_e = exp_len_q.pop_front();
                    check("len_on_upd", o_len, mon_e);
                end
            end
            if (o_ext_ack === 1'b1) begin
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ext_ack: got 1 expected 0");
                end else begin
                    void'(exp_ack_q.pop_front());
                    checks++;
                end
            end
        end
    end

    task automatic press_hi(input int ticks);
        @(negedge clk) btn = 1'b1;
        @(negedge clk) btn = 1'b0;
        @(negedge clk) btn = 1'b1;
        @(negedge clk) btn = 1'b0;
        @(negedge clk) btn = 1'b1;
        repeat (ticks * DIV) @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic press(input int ticks);
        press_hi(ticks);
        repeat (4 * DIV) @(negedge clk);
        repeat (2 * DIV) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        // 1: reset with button held, debounce latency
        btn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("rst_len", o_len, 0);
        check("rst_pending", o_pending, 0);
        check("rst_len_upd", o_len_upd, 0);
        check("rst_ext_ack", o_ext_ack, 0);
        check("rst_sample_en", o_sample_en, 0);
        check("rst_btn_stable", o_btn_stable, 0);
        repeat (40) @(negedge clk);
        check("stable_not_before_3_ticks", o_btn_stable, 0);
        repeat (20) @(negedge clk);
        check("stable_after_3_ticks", o_btn_stable, 1);
        rst = 1'b1;
        btn = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rerst_btn_stable", o_btn_stable, 0);
        check("rerst_pending", o_pending, 0);

        // 2: short press, bus quiet, apply latency
        cs = 1'b0;
        exp_len_q.push_back(4'd1);
        seen = 1'b0;
        n = 0;
        fork
            press(4);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (o_pending) seen = 1'b1;
                end
                check("pending_rise_seen", seen, 1);
                if (seen) begin
                    while (o_len !== 4'd1 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    check("apply_latency_clks", n, 5);
                end
            end
        join
        check("t2_len", o_len, 1);
        check("t2_pending", o_pending, 0);

        // 3: press while cs busy, then quiet window interrupted
        @(negedge clk) cs = 1'b1;
        exp_len_q.push_back(4'd2);
        press(4);
        check("t3_len_held_busy", o_len, 1);
        check("t3_pending_busy", o_pending, 1);
        @(negedge clk) cs = 1'b0;
        @(negedge clk);
        @(negedge clk) cs = 1'b1;
        @(negedge clk) cs = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_len_after_restart_4", o_len, 1);
        check("t3_pending_after_restart_4", o_pending, 1);
        @(negedge clk);
        check("t3_len_after_restart_5", o_len, 2);

        // 4: wrap at len_max=2, starting from len=2
        len_max = 4'd2;
        exp_len_q.push_back(4'd0);
        press(4);
        check("t4_wrap_to_0", o_len, 0);
        exp_len_q.push_back(4'd1);
        press(4);
        check("t4_step_1", o_len, 1);
        exp_len_q.push_back(4'd2);
        press(4);
        check("t4_step_2", o_len, 2);

        // 5: long press zeroes before release; release ignored
        len_max = 4'd15;
        exp_len_q.push_back(4'd0);
        press_hi(14);
        check("t5_len_before_release", o_len, 0);
        check("t5_stable_held", o_btn_stable, 1);
        repeat (6 * DIV) @(negedge clk);
        check("t5_len_after_release", o_len, 0);
        check("t5_pending_after_release", o_pending, 0);

        // 6: ext_load coincident with short-press release
        len_max = 4'd5;
        press_hi(4);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!o_btn_stable) seen = 1'b1;
        end
        check("t6_fall_seen", seen, 1);
        ext_load = 1'b1;
        ext_len  = 4'd9;
        exp_ack_q.push_back(1'b1);
        exp_len_q.push_back(4'd5);
        @(negedge clk) ext_load = 1'b0;
        check("t6_ext_ack_next_clk", o_ext_ack, 1);
        repeat (4 * DIV) @(negedge clk);
        check("t6_len_clamped", o_len, 5);

        // 7: plain host load, then len_max=0 presses
        len_max  = 4'd15;
        ext_load = 1'b1;
        ext_len  = 4'd3;
        exp_ack_q.push_back(1'b1);
        exp_len_q.push_back(4'd3);
        @(negedge clk) ext_load = 1'b0;
        repeat (20) @(negedge clk);
        check("t7_ext_len", o_len, 3);
        len_max = 4'd0;
        exp_len_q.push_back(4'd0);
        press(4);
        check("t7_max0_first", o_len, 0);
        press(4);
        check("t7_max0_second", o_len, 0);
        check("t7_max0_pending", o_pending, 0);

        repeat (10) @(negedge clk);
        check("len_queue_drained", exp_len_q.size(), 0);
        check("ack_queue_drained", exp_ack_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
